// File: rtl/ssm_tile_pkg.sv
// ==== ssm_tile_pkg : shared types and tiling constants for the tiled SSM datapath ====
// ==== Rev 1.0 ====
`default_nettype none

package ssm_tile_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int DEF_H       = 24;
  localparam int DEF_P       = 64;
  localparam int DEF_H_TILE  = 12;
  localparam int DEF_P_TILE  = 16;
  localparam int DEF_DW      = 16;

  localparam int NUM_TILE_H  = DEF_H / DEF_H_TILE;
  localparam int NUM_TILE_P  = DEF_P / DEF_P_TILE;
  localparam int BEAT_W      = DEF_P_TILE * DEF_DW;
  localparam int BEATS_TOTAL = NUM_TILE_H * NUM_TILE_P * DEF_H_TILE;

  // Index width that stays legal (>=1) for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tile_gather_if.sv
// ==== tile_gather_if : row-beat valid/ready stream from the tile engine ====
// ==== Rev 1.0 ====
`default_nettype none

interface tile_gather_if #(
  parameter int BEAT_W = 256
);
  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data;
  logic              in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

`default_nettype wire

// File: rtl/tile_idx_counter.sv
// ==== tile_idx_counter : nested row / p_idx / h_idx tile position counter ====
// ==== Rev 1.0 ====
`default_nettype none

module tile_idx_counter
  import ssm_tile_pkg::*;
#(
  parameter int H_TILE = 12,
  parameter int NUM_P  = 4,
  parameter int NUM_H  = 2,
  localparam int RW    = idx_w(H_TILE),
  localparam int PW    = idx_w(NUM_P),
  localparam int HW    = idx_w(NUM_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [PW-1:0] p_idx,
  output logic [HW-1:0] h_idx,
  output logic          row_last,
  output logic          all_last
);

  logic w_p_last;
  logic w_h_last;

  assign row_last = (row   == RW'(H_TILE - 1));
  assign w_p_last = (p_idx == PW'(NUM_P - 1));
  assign w_h_last = (h_idx == HW'(NUM_H - 1));
  assign all_last = row_last & w_p_last & w_h_last;

  // Row is the fastest digit; each wrap carries into the next slower one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row   <= '0;
      p_idx <= '0;
      h_idx <= '0;
    end else if (clr) begin
      row   <= '0;
      p_idx <= '0;
      h_idx <= '0;
    end else if (en) begin
      if (row_last) begin
        row <= '0;
        if (w_p_last) begin
          p_idx <= '0;
          h_idx <= w_h_last ? '0 : h_idx + HW'(1);
        end else begin
          p_idx <= p_idx + PW'(1);
        end
      end else begin
        row <= row + RW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tile_gather.sv
// ==== tile_gather : scatters tile row beats into the full-size y register ====
// ==== Rev 1.0 ====
`default_nettype none

module tile_gather
  import ssm_tile_pkg::*;
#(
  parameter int B      = 1,
  parameter int H      = 24,
  parameter int P      = 64,
  parameter int H_TILE = 12,
  parameter int P_TILE = 16,
  parameter int DW     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  tile_gather_if.slave          in_if,
  output logic [B*H*P*DW-1:0]   y_flat_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NTH    = H / H_TILE;
  localparam int NTP    = P / P_TILE;
  localparam int BEAT_W = P_TILE * DW;
  localparam int YW     = B * H * P * DW;
  localparam int YIW    = idx_w(YW);
  localparam int RW     = idx_w(H_TILE);
  localparam int PW     = idx_w(NTP);
  localparam int HW     = idx_w(NTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_fire;
  logic             w_clr;
  logic [RW-1:0]    w_row;
  logic [PW-1:0]    w_p;
  logic [HW-1:0]    w_h;
  logic             w_row_last;
  logic             w_all_last;
  int               w_elem;
  logic [YIW-1:0]   w_lo;

  tile_idx_counter #(
    .H_TILE (H_TILE),
    .NUM_P  (NTP),
    .NUM_H  (NTH)
  ) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_clr),
    .en       (w_fire),
    .row      (w_row),
    .p_idx    (w_p),
    .h_idx    (w_h),
    .row_last (w_row_last),
    .all_last (w_all_last)
  );

  // Ready comes straight from the state register, never from in_valid.
  assign in_if.in_ready = (r_state == RECV);

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RECV;
          w_clr       = 1'b1;
        end
      end
      RECV: begin
        w_fire = in_if.in_valid;
        if (w_fire && w_all_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A beat's lanes are contiguous in y, so one row-wide slice is written.
  always_comb begin
    w_elem = (int'(w_h) * H_TILE + int'(w_row)) * P + int'(w_p) * P_TILE;
    w_lo   = YIW'(w_elem * DW);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt == RECV);
      done    <= w_fire & w_all_last;
      if (w_clr) begin
        err <= 1'b0;
      end else if (w_fire && (in_if.in_last != w_row_last)) begin
        err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_flat_out <= '0;
    end else if (w_fire) begin
      y_flat_out[w_lo +: BEAT_W] <= in_if.in_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tile_gather.sv
// ==== tb_tile_gather : directed self-checking bench for tile_gather (H=4 P=8 H_TILE=2 P_TILE=4) ====
// ==== Rev 1.0 ====
`default_nettype none

module tb_tile_gather;

  localparam int H      = 4;
  localparam int P      = 8;
  localparam int H_TILE = 2;
  localparam int P_TILE = 4;
  localparam int DW     = 16;
  localparam int BEAT_W = P_TILE * DW;
  localparam int YW     = H * P * DW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [YW-1:0] y_flat_out;
  logic          busy;
  logic          done;
  logic          err;

  logic [YW-1:0] ref_y;
  int            n_chk;
  int            n_pass;

  tile_gather_if #(.BEAT_W(BEAT_W)) bus ();

  tile_gather #(
    .B      (1),
    .H      (H),
    .P      (P),
    .H_TILE (H_TILE),
    .P_TILE (P_TILE),
    .DW     (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_if      (bus),
    .y_flat_out (y_flat_out),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [YW-1:0] got, input logic [YW-1:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat k lane j carries 16'h0k0j.
  function automatic logic [BEAT_W-1:0] beat_data(input int k);
    logic [BEAT_W-1:0] d;
    for (int j = 0; j < P_TILE; j++) d[DW*j +: DW] = {8'(k), 8'(j)};
    return d;
  endfunction

  // Beat k -> row=k%2, p_idx=(k/2)%2, h_idx=k/4; element base (h*2+row)*8 + p*4.
  function automatic logic [YW-1:0] exp_y();
    logic [YW-1:0] y;
    int r, p, h, e;
    y = '0;
    for (int k = 0; k < 8; k++) begin
      r = k % 2;
      p = (k / 2) % 2;
      h = k / 4;
      e = (h * 2 + r) * 8 + p * 4;
      y[DW*e +: BEAT_W] = beat_data(k);
    end
    return y;
  endfunction

  task automatic drive_beat(input int k, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = beat_data(k);
    bus.in_last  = last;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int k;
    int extra_done;
    logic v;
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    ref_y = exp_y();
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ready", bus.in_ready, 0);
    check("rst_y", y_flat_out, 0);
    rst = 1'b1;
    tick();

    // Back-to-back collection
    do_start();
    check("b2b_busy", busy, 1);
    check("b2b_ready", bus.in_ready, 1);
    for (int b = 0; b < 8; b++) begin
      drive_beat(b, (b % 2) == 1);
      tick();
      if (b == 2) check("b2b_beat2", y_flat_out[64 +: 64], 64'h0203_0202_0201_0200);
      if (b == 5) check("b2b_beat5", y_flat_out[384 +: 64], 64'h0503_0502_0501_0500);
      if (b < 7) check("b2b_no_early_done", done, 0);
    end
    bus.in_valid = 1'b0;
    check("b2b_done", done, 1);
    check("b2b_busy_end", busy, 0);
    check("b2b_ready_end", bus.in_ready, 0);
    check("b2b_err", err, 0);
    check("b2b_y", y_flat_out, ref_y);
    tick();
    check("b2b_done_pulse", done, 0);

    // Throttled input, valid pattern 1,0,0,1,...
    apply_reset();
    do_start();
    k = 0;
    extra_done = 0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      v = ((c % 3) == 0);
      if (v) drive_beat(k, (k % 2) == 1);
      else bus.in_valid = 1'b0;
      tick();
      if (v) k++;
      if (v && k == 8) check("thr_done", done, 1);
      else if (done) extra_done++;
    end
    bus.in_valid = 1'b0;
    check("thr_beats", k, 8);
    check("thr_extra_done", extra_done, 0);
    check("thr_y", y_flat_out, ref_y);
    tick();
    check("thr_busy_end", busy, 0);

    // Framing error on beat 0
    apply_reset();
    do_start();
    drive_beat(0, 1'b1);
    tick();
    check("frm_err_set", err, 1);
    for (int b = 1; b < 8; b++) begin
      drive_beat(b, (b % 2) == 1);
      tick();
    end
    bus.in_valid = 1'b0;
    check("frm_done", done, 1);
    check("frm_err_sticky", err, 1);
    check("frm_y", y_flat_out, ref_y);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("frm_err_clr", err, 0);
    check("frm_rearm_busy", busy, 1);

    // Reset mid-collection after 3 beats
    for (int b = 0; b < 3; b++) begin
      drive_beat(b, (b % 2) == 1);
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("rmid_y_zero", y_flat_out, 0);
    check("rmid_ready", bus.in_ready, 0);
    check("rmid_busy", busy, 0);
    check("rmid_err", err, 0);
    check("rmid_done", done, 0);
    tick();
    rst = 1'b1;
    tick();
    do_start();
    for (int b = 0; b < 8; b++) begin
      drive_beat(b, (b % 2) == 1);
      tick();
    end
    bus.in_valid = 1'b0;
    check("rmid_done_after", done, 1);
    check("rmid_y", y_flat_out, ref_y);
    tick();

    // Valid in IDLE is rejected
    bus.in_valid = 1'b1;
    bus.in_data = '1;
    bus.in_last = 1'b1;
    tick();
    check("idle_ready", bus.in_ready, 0);
    tick();
    tick();
    bus.in_valid = 1'b0;
    check("idle_y", y_flat_out, ref_y);

    // Start during RECV is ignored
    do_start();
    for (int b = 0; b < 8; b++) begin
      drive_beat(b, (b % 2) == 1);
      start = (b == 4);
      tick();
      start = 1'b0;
      if (b >= 4 && b < 7) check("ign_no_done", done, 0);
    end
    bus.in_valid = 1'b0;
    check("ign_done", done, 1);
    check("ign_busy", busy, 0);
    check("ign_y", y_flat_out, ref_y);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
